// File: rtl/traffic_pkg.sv
// Shared encodings for the multi-approach traffic signal controller.
// Lamp codes, phase enum and the approach-index width helper.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    function automatic int dir_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first set request bit at or after start,
// wrapping modulo NUM_DIR.
module rr_next_sel
    import traffic_pkg::*;
#(
    parameter int  NUM_DIR = 4,
    localparam int DIR_W   = dir_w(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [DIR_W-1:0]   start,
    output logic [DIR_W-1:0]   idx,
    output logic               valid
);

    int j;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = NUM_DIR - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= NUM_DIR) begin
                j = j - NUM_DIR;
            end
            if (j < NUM_DIR && req[j]) begin
                idx   = DIR_W'(j);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Demand-actuated signal controller for NUM_DIR approaches.
// Optional emergency preemption: define TRAFFIC_EMERG_PREEMPT_EN.
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int  NUM_DIR    = 4,
    parameter int  GREEN_CYC  = 4,
    parameter int  YELLOW_CYC = 4,
    parameter int  ALLRED_CYC = 1,
    parameter int  CNT_W      = 8,
    localparam int DIR_W      = dir_w(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_DIR-1:0]   sensor,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    input  logic                 emerg_req,
    input  logic [DIR_W-1:0]     emerg_dir,
`endif
    output logic [3*NUM_DIR-1:0] lights,
    output logic [DIR_W-1:0]     active_dir,
    output logic [1:0]           phase
);

    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] A_LAST =
        CNT_W'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);
    localparam logic [DIR_W-1:0] D_LAST = DIR_W'(NUM_DIR - 1);

    phase_e             state, state_nx;
    logic [CNT_W-1:0]   timer, timer_nx;
    logic [DIR_W-1:0]   next_dir, next_dir_nx, active_nx;
    logic [DIR_W-1:0]   start, sel_idx, emg_dir, tgt_dir;
    logic [NUM_DIR-1:0] pend, act_oh, dem, grn_mask;
    logic               sel_vld, emg_vld;

`ifdef TRAFFIC_EMERG_PREEMPT_EN
    assign emg_vld = emerg_req && (int'(emerg_dir) < NUM_DIR);
    assign emg_dir = emerg_dir;
`else
    assign emg_vld = 1'b0;
    assign emg_dir = '0;
`endif

    always_comb begin
        act_oh = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            act_oh[i] = (active_dir == DIR_W'(i));
        end
    end

    assign grn_mask = (state == PH_GREEN) ? act_oh : '0;
    assign dem      = (pend | sensor) & ~act_oh;
    assign start    = (active_dir == D_LAST) ? '0 : active_dir + 1'b1;
    assign tgt_dir  = emg_vld ? emg_dir : next_dir;

    rr_next_sel #(
        .NUM_DIR(NUM_DIR)
    ) u_sel (
        .req  (dem),
        .start(start),
        .idx  (sel_idx),
        .valid(sel_vld)
    );

    always_comb begin
        state_nx    = state;
        timer_nx    = timer + 1'b1;
        next_dir_nx = next_dir;
        active_nx   = active_dir;
        unique case (state)
            PH_GREEN: begin
                if (timer == G_LAST) begin
                    timer_nx = timer;
                end
                if (emg_vld && emg_dir != active_dir) begin
                    state_nx    = PH_YELLOW;
                    timer_nx    = '0;
                    next_dir_nx = emg_dir;
                end else if (!emg_vld && timer == G_LAST && sel_vld) begin
                    state_nx    = PH_YELLOW;
                    timer_nx    = '0;
                    next_dir_nx = sel_idx;
                end
            end
            PH_YELLOW: begin
                next_dir_nx = tgt_dir;
                if (timer == Y_LAST) begin
                    timer_nx = '0;
                    if (ALLRED_CYC == 0) begin
                        state_nx  = PH_GREEN;
                        active_nx = tgt_dir;
                    end else begin
                        state_nx = PH_ALLRED;
                    end
                end
            end
            PH_ALLRED: begin
                next_dir_nx = tgt_dir;
                if (timer == A_LAST) begin
                    state_nx  = PH_GREEN;
                    timer_nx  = '0;
                    active_nx = tgt_dir;
                end
            end
            default: begin
                state_nx = PH_GREEN;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PH_GREEN;
            timer      <= '0;
            next_dir   <= '0;
            active_dir <= '0;
            pend       <= '0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            next_dir   <= next_dir_nx;
            active_dir <= active_nx;
            pend       <= (pend | sensor) & ~grn_mask;
        end
    end

    always_comb begin
        lights = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            lights[3*i +: 3] = LT_RED;
            if (act_oh[i] && state == PH_GREEN) begin
                lights[3*i +: 3] = LT_GRN;
            end
            if (act_oh[i] && state == PH_YELLOW) begin
                lights[3*i +: 3] = LT_YEL;
            end
        end
    end

    assign phase = state;

endmodule

// File: doc/traffic_ctrl_multi.md
Name: traffic_ctrl_multi

Overview:
Parametrised, demand-actuated signal controller for NUM_DIR approaches, the next generation of the fixed 4-way round-robin controller.
- Adds configurable green, yellow and all-red clearance durations.
- Adds per-approach vehicle sensors; approaches with no demand are skipped, and green rests on the current approach when nothing else is waiting.
- Sits between sensor front-ends and lamp drivers.

Parameters:
NUM_DIR, 4, number of approaches; 0=north, 1=west, 2=south, 3=east; legal range >=2
GREEN_CYC, 4, minimum green cycles per approach; >=1
YELLOW_CYC, 4, yellow cycles; >=1
ALLRED_CYC, 1, all-red clearance cycles; 0 means ALLRED is skipped
CNT_W, 8, phase timer width; every duration must be < 2**CNT_W

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  asynchronous, active-high reset
sensor  in  NUM_DIR  level vehicle demand, one bit per approach
lights  out  3*NUM_DIR  approach i occupies [3i+2:3i]; 100=red, 010=yellow, 001=green
active_dir  out  DIR_W  approach currently green/yellow; DIR_W=max(1,$clog2(NUM_DIR))
phase  out  2  00=GREEN, 01=YELLOW, 10=ALLRED

Behaviour:
- Reset (async assert, sync release):
  - state=GREEN, active_dir=0, timer=0, next_dir=0, pend=0.
  - lights: approach 0 = 001, all others = 100; phase=00.
- Outputs are decoded only from registered state. There is no combinational path from input to output.
- Light decode:
  - GREEN: active approach 001.
  - YELLOW: active approach 010.
  - ALLRED: every approach 100.
  - Non-active approaches are always 100.
  - At most one approach is non-red at any time.
- pend register, updated every cycle:
  - pend[i] <= (pend[i] | sensor[i]) & ~(state==GREEN && active_dir==i).
  - The green approach never accumulates demand for itself.
- Demand vector: dem = pend | sensor, with the active_dir bit masked off.
- Timer: resets to 0 on every state change and increments each cycle in the state.
  - In GREEN it saturates at GREEN_CYC-1.
- GREEN:
  - If timer==GREEN_CYC-1 and dem!=0: go to YELLOW.
  - On the same edge, latch next_dir = first set bit of dem, searching round-robin from active_dir+1 modulo NUM_DIR.
  - If dem==0: stay GREEN indefinitely (rest-in-green).
- YELLOW:
  - If timer==YELLOW_CYC-1: go to ALLRED, or straight to GREEN when ALLRED_CYC==0.
  - On entry to GREEN, active_dir <= next_dir.
- ALLRED:
  - If timer==ALLRED_CYC-1: go to GREEN with active_dir <= next_dir.
- Committed transitions:
  - next_dir is fixed once latched. A sensor drop during YELLOW/ALLRED does not cancel the transition.
  - A new request arriving during YELLOW/ALLRED stays in pend for a later rotation.
- With continuous demand, each green lasts exactly GREEN_CYC cycles and yellow exactly YELLOW_CYC cycles.
- Wrap-around: after the highest index, the search continues at 0. Active index wrap is modulo NUM_DIR, including non-power-of-2 values.
- Reset mid-phase immediately forces the reset state, discarding the latched next_dir and pend.

Optional Feature:
Macro TRAFFIC_EMERG_PREEMPT_EN.
- When defined, adds ports emerg_req (in, 1) and emerg_dir (in, DIR_W).
- While emerg_req=1:
  - In GREEN with active_dir!=emerg_dir: go to YELLOW next edge regardless of timer, with next_dir=emerg_dir.
  - In GREEN with active_dir==emerg_dir: hold GREEN, with no yellow even if dem!=0.
  - In YELLOW/ALLRED: next_dir is overwritten with emerg_dir. Yellow and all-red durations are never shortened.
- emerg_dir >= NUM_DIR is ignored.
- When undefined: the ports do not exist and behaviour is exactly as above.

Decomposition:
- Package traffic_pkg holds:
  - light encodings LT_RED=3'b100, LT_YEL=3'b010, LT_GRN=3'b001
  - phase enum PH_GREEN/PH_YELLOW/PH_ALLRED
- One sub-module, rr_next_sel: combinational round-robin search (request vector, start index) -> index plus valid. It is parametrised by NUM_DIR.

Test Plan:
1. Defaults, sensor=0, reset held 2 cycles then released -> lights=100_100_100_001 for 20+ cycles, phase=00, active_dir=0.
2. Defaults, sensor=4'b0010 from release -> north green 4 cycles, then north yellow 4 cycles, then all-red 1 cycle, then west 001 with active_dir=1; pend[1] clear.
3. sensor=4'b1111 continuous -> green order 0,1,2,3,0, each green 4 cycles, period 36 cycles; never two non-red approaches at once.
4. Only sensor[3] pulsed 1 cycle during north green -> next green is east (skips 1, 2); pulse during east green is not latched.
5. NUM_DIR=3, ALLRED_CYC=0, sensor=3'b001 while active=2 -> wrap to 0, yellow goes directly to green, no 100-all cycle.
6. Reset asserted mid-YELLOW of west -> lights=…_001 on north asynchronously, pend cleared; with macro, emerg_req=1, emerg_dir=2 at north green timer=1 -> yellow next cycle, then south green.
